// File: rtl/kbd_pkg.sv
// Shared scan-code constants, parser states and event layout for the PS/2 key event decoder.
// When KBD_ASCII_LUT_EN is defined the package also provides the Set-2 to ASCII lookup.
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Bytes that follow E1 in the Pause sequence; none of them form an event.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  localparam int EVT_CORE_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } parse_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
    logic [7:0] ascii;
  } kbd_evt_t;

  // Keyboard status/ack bytes that never describe a key.
  function automatic logic is_dropped(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

`ifdef KBD_ASCII_LUT_EN
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic ext,
                                               input logic shift);
    logic       letter;
    logic       digit;
    logic [7:0] ofs;
    {letter, digit, ofs} = {2'b10, 8'd0};
    case (code)
      8'h1C: ofs = 8'd0;   8'h32: ofs = 8'd1;   8'h21: ofs = 8'd2;   8'h23: ofs = 8'd3;
      8'h24: ofs = 8'd4;   8'h2B: ofs = 8'd5;   8'h34: ofs = 8'd6;   8'h33: ofs = 8'd7;
      8'h43: ofs = 8'd8;   8'h3B: ofs = 8'd9;   8'h42: ofs = 8'd10;  8'h4B: ofs = 8'd11;
      8'h3A: ofs = 8'd12;  8'h31: ofs = 8'd13;  8'h44: ofs = 8'd14;  8'h4D: ofs = 8'd15;
      8'h15: ofs = 8'd16;  8'h2D: ofs = 8'd17;  8'h1B: ofs = 8'd18;  8'h2C: ofs = 8'd19;
      8'h3C: ofs = 8'd20;  8'h2A: ofs = 8'd21;  8'h1D: ofs = 8'd22;  8'h22: ofs = 8'd23;
      8'h35: ofs = 8'd24;  8'h1A: ofs = 8'd25;
      8'h45: {letter, digit, ofs} = {2'b01, 8'd0};
      8'h16: {letter, digit, ofs} = {2'b01, 8'd1};
      8'h1E: {letter, digit, ofs} = {2'b01, 8'd2};
      8'h26: {letter, digit, ofs} = {2'b01, 8'd3};
      8'h25: {letter, digit, ofs} = {2'b01, 8'd4};
      8'h2E: {letter, digit, ofs} = {2'b01, 8'd5};
      8'h36: {letter, digit, ofs} = {2'b01, 8'd6};
      8'h3D: {letter, digit, ofs} = {2'b01, 8'd7};
      8'h3E: {letter, digit, ofs} = {2'b01, 8'd8};
      8'h46: {letter, digit, ofs} = {2'b01, 8'd9};
      default: letter = 1'b0;
    endcase
    if (ext)    return 8'hFF;
    if (letter) return (shift ? 8'h41 : 8'h61) + ofs;
    if (digit)  return 8'h30 + ofs;
    return 8'hFF;
  endfunction
`endif

endpackage

// File: rtl/kbd_evt_fifo.sv
// Show-ahead event FIFO: head word visible on dout, occupancy on level.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module kbd_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 byte stream to key events (make/break, E0, typematic repeat) with an event FIFO.
// Define KBD_ASCII_LUT_EN to store an ASCII translation with each event.
module ps2_key_event_decoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ack,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [7:0]             ev_code,
  output logic                   ev_ext,
  output logic                   ev_break,
  output logic                   ev_repeat,
  output logic [7:0]             ev_ascii,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       press_cnt,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  import kbd_pkg::*;

`ifdef KBD_ASCII_LUT_EN
  localparam int FIFO_W = $bits(kbd_evt_t);
`else
  localparam int FIFO_W = EVT_CORE_W;
`endif

  parse_state_t       state;
  parse_state_t       state_nx;
  logic [2:0]         skip_cnt;
  logic [8:0]         last_make;
  logic               last_vld;
  logic               accept;
  logic               emit;
  logic               dec_ext;
  logic               dec_brk;
  logic               dec_rpt;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;
  logic               drop;
  logic [FIFO_W-1:0]  fifo_din;
  logic [FIFO_W-1:0]  fifo_dout;
  logic [7:0]         head_code;
  logic               head_ext;
  logic               head_brk;
  logic               head_rpt;

  // in_ack doubles as the one-cycle lockout that limits intake to one byte per two cycles.
  assign accept = in_valid && !in_ack;

  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    dec_ext  = 1'b0;
    dec_brk  = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (in_data == SC_EXT)        state_nx = ST_E0;
          else if (in_data == SC_BRK)   state_nx = ST_F0;
          else if (in_data == SC_PAUSE) state_nx = ST_SKIP;
          else if (!is_dropped(in_data)) emit = 1'b1;
        end
        ST_E0: begin
          state_nx = ST_IDLE;
          if (in_data == SC_BRK) begin
            state_nx = ST_E0F0;
          end else if (in_data != SC_EXT && in_data != SC_PAUSE) begin
            emit    = 1'b1;
            dec_ext = 1'b1;
          end
        end
        ST_F0: begin
          state_nx = ST_IDLE;
          emit     = 1'b1;
          dec_brk  = 1'b1;
        end
        ST_E0F0: begin
          state_nx = ST_IDLE;
          emit     = 1'b1;
          dec_ext  = 1'b1;
          dec_brk  = 1'b1;
        end
        ST_SKIP: begin
          if (skip_cnt == 3'd1) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign dec_rpt  = !dec_brk && last_vld && (last_make == {dec_ext, in_data});
  assign fifo_pop = ev_ready && !fifo_empty;
  assign drop     = emit && fifo_full && !fifo_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      last_make <= '0;
      last_vld  <= 1'b0;
      press_cnt <= '0;
      in_ack    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      in_ack <= accept;
      state  <= state_nx;
      if (accept && state == ST_IDLE && in_data == SC_PAUSE) skip_cnt <= PAUSE_TAIL;
      else if (accept && state == ST_SKIP)                   skip_cnt <= skip_cnt - 1'b1;
      // press_cnt tracks keystrokes even when the FIFO has to drop the event.
      if (emit && !dec_brk && !dec_rpt) begin
        last_make <= {dec_ext, in_data};
        last_vld  <= 1'b1;
        press_cnt <= press_cnt + 1'b1;
      end else if (emit && dec_brk && last_vld && last_make == {dec_ext, in_data}) begin
        last_vld <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef KBD_ASCII_LUT_EN
  logic     lshift;
  logic     rshift;
  kbd_evt_t evt_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
    end else if (emit && !dec_ext) begin
      if (in_data == SC_LSHIFT) lshift <= !dec_brk;
      if (in_data == SC_RSHIFT) rshift <= !dec_brk;
    end
  end

  // Shift state is sampled before this event's own update, so a shift make reads unshifted.
  assign evt_in = '{code:  in_data,
                    ext:   dec_ext,
                    brk:   dec_brk,
                    rpt:   dec_rpt,
                    ascii: scan_to_ascii(in_data, dec_ext, lshift || rshift)};
  assign fifo_din = evt_in;
  assign ev_ascii = fifo_empty ? 8'hFF : fifo_dout[7:0];
`else
  assign fifo_din = {in_data, dec_ext, dec_brk, dec_rpt};
  assign ev_ascii = 8'hFF;
`endif

  kbd_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (emit),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Head fields read as zero while empty so the outputs never show stale entries.
  assign {head_code, head_ext, head_brk, head_rpt} = fifo_dout[FIFO_W-1 -: EVT_CORE_W];
  assign ev_valid  = !fifo_empty;
  assign ev_code   = fifo_empty ? 8'h00 : head_code;
  assign ev_ext    = !fifo_empty && head_ext;
  assign ev_break  = !fifo_empty && head_brk;
  assign ev_repeat = !fifo_empty && head_rpt;

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Turns the raw PS/2 scan-code byte stream from the PS/2 receiver into whole key events (make/break, extended, typematic repeat).
- Queues events in a show-ahead FIFO with a valid/ready handshake.
- Keeps a wrapping key-press counter for the 7-segment count display.
- Replaces the single-register "current key" path with a buffered, multi-byte-aware decoder.

Parameters:
- DEPTH, 8: event FIFO entries; power of two, at least 2.
- CNT_W, 8: press counter width.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  receiver has a byte (receiver "ready").
- in_data  in  8  scan-code byte.
- in_ack  out  1  one-cycle pulse: byte consumed.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer pops the head when ev_valid is also high.
- ev_code  out  8  head scan code, prefixes stripped.
- ev_ext  out  1  head event was E0-prefixed.
- ev_break  out  1  head event is a release.
- ev_repeat  out  1  head event is a typematic repeat make.
- ev_ascii  out  8  head ASCII code (see Optional Feature).
- fifo_level  out  $clog2(DEPTH)+1  number of entries.
- press_cnt  out  CNT_W  count of non-repeat makes.
- overflow  out  1  sticky: an event was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset: all outputs 0 except ev_ascii=8'hFF. FIFO empty, parser in IDLE, last_make cleared (invalid), shift state cleared. Reset mid-sequence discards any partial prefix.
- Byte intake: a byte is consumed at an edge where in_valid=1 and in_ack=0. in_ack=1 for exactly the following cycle. in_valid is ignored while in_ack=1. Maximum rate: one byte per 2 cycles.
- Parser states: IDLE, E0, F0, E0F0, SKIP.
  - IDLE: E0->E0; F0->F0; E1->SKIP with skip counter=7; AA, FA, FE, EE, 00, FF dropped (stay IDLE); any other byte emits a make, ext=0.
  - E0: F0->E0F0; E0 or E1 -> IDLE, dropped; other byte emits a make, ext=1.
  - F0: emits a break, ext=0. E0F0: emits a break, ext=1.
  - SKIP: decrement the counter per byte; go to IDLE when the 7th byte is consumed. The Pause sequence produces no event.
  - Every emit returns the parser to IDLE.
- Repeat: a make whose {ext,code} equals last_make while last_make is valid gets repeat=1 and does not increment press_cnt. Any other make sets last_make and increments press_cnt (wraps at 2^CNT_W). A break matching last_make invalidates it.
- Emit latency: the event is pushed on the same edge its final byte is consumed. ev_valid rises the next cycle if the FIFO was empty.
- FIFO: the head is visible combinationally on the ev_* outputs. Pop occurs when ev_valid&&ev_ready.
  - Push and pop on the same edge is allowed, including when full: the level is unchanged and nothing is dropped.
  - Push while full with no pop drops the new event and sets overflow. press_cnt still updates.
  - clr_ovf and a new drop on the same edge: overflow stays 1.
  - Pop on empty is ignored.
- Shift tracking: makes/breaks of 12h and 59h (ext=0) set/clear lshift/rshift. Shift events are still queued.

Optional Feature:
- Macro: KBD_ASCII_LUT_EN.
- Defined:
  - The ASCII code is computed at push and stored in the entry.
  - Set-2 letters 1C..1A map to 'a'..'z', or 'A'..'Z' if either shift is held.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'.
  - ext=1 or any unmapped code gives FFh.
- Undefined: no LUT and no FIFO ASCII storage. ev_ascii is constant 8'hFF.

Decomposition:
- Shared package kbd_pkg holds:
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_PAUSE=E1, SC_LSHIFT=12, SC_RSHIFT=59, and the drop list.
  - Parser state enum.
  - Packed event typedef {code, ext, brk, rpt, ascii}.
- One natural sub-module: kbd_evt_fifo, a parametrised DEPTH x event-width show-ahead FIFO with level and full/empty.

Test Plan:
- Byte 1C, then F0 1C, with ev_ready=1 -> two events {1C,ext0,brk0,rpt0} then {1C,brk1}; press_cnt=1; each in_ack is a single pulse.
- E0 75, E0 F0 75 -> {75,ext1,brk0} then {75,ext1,brk1}; an extended make counts in press_cnt.
- 1C,1C,1C, then F0 1C -> rpt=0,1,1 then break; press_cnt=1. A following 1C gives rpt=0 and press_cnt=2.
- ev_ready=0 while feeding DEPTH+1 makes (DEPTH=8) -> fifo_level=8, overflow=1, 9th event lost. clr_ovf gives overflow=0. Draining returns the 8 events in order.
- E1 14 77 E1 F0 14 F0 77, then 32 -> only one event, {32}. Reset asserted mid-way through E0 F0 -> FIFO empty and next 1C decodes as a plain make.
- KBD_ASCII_LUT_EN: 12 (shift make), 1C -> ascii 41h. Then F0 12, 1C -> ascii 61h. 45 -> 30h; E0 1C -> FFh.
